// File: rtl/io_arb_pkg.sv
// Shared types for the IO bus arbiter: FSM state encoding and bus word types.
package io_arb_pkg;

  typedef logic [31:0] io_addr_t;
  typedef logic [31:0] io_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StReadWait,
    StRespond
  } io_arb_state_t;

  // Largest supported requester count.
  localparam int unsigned MaxRequesters = 16;

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over a request vector, starting the search
// at a priority pointer that moves to one past the granted index on update_pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      update_pointer,
  output logic [NUM_REQUESTERS-1:0] grant
);

  localparam int unsigned PtrW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PtrW-1:0]           ptr_q, ptr_d;
  logic [PtrW-1:0]           win_idx;
  logic [NUM_REQUESTERS-1:0] upper_mask;
  logic [NUM_REQUESTERS-1:0] upper_req;
  logic [NUM_REQUESTERS-1:0] pick;

  // Pick the lowest request at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    upper_mask = '0;
    for (int j = 0; j < int'(NUM_REQUESTERS); j++) begin
      upper_mask[j] = (j >= int'(ptr_q));
    end
    upper_req = req & upper_mask;
    pick      = (|upper_req) ? upper_req : req;
    grant     = '0;
    win_idx   = '0;
    for (int j = int'(NUM_REQUESTERS) - 1; j >= 0; j--) begin
      if (pick[j]) begin
        grant      = '0;
        grant[j]   = 1'b1;
        win_idx    = PtrW'(j);
      end
    end
  end

  // Advance the pointer past the current winner; with one requester it stays at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (update_pointer && |req) begin
      ptr_d = (win_idx == PtrW'(NUM_REQUESTERS - 1)) ? '0 : win_idx + PtrW'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Serialises requester transactions onto the single-master IO bus, granting
// round-robin and routing read data back to the requester that issued it.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic     [NUM_REQUESTERS-1:0]       req_valid,
  input  logic     [NUM_REQUESTERS-1:0]       req_write,
  input  io_addr_t [NUM_REQUESTERS-1:0]       req_address,
  input  io_data_t [NUM_REQUESTERS-1:0]       req_write_data,
  output logic     [NUM_REQUESTERS-1:0]       req_ack,
  output logic     [NUM_REQUESTERS-1:0]       resp_valid,
  output io_data_t                            resp_read_data,
  output logic                                io_write_en,
  output logic                                io_read_en,
  output io_addr_t                            io_address,
  output io_data_t                            io_write_data,
  input  io_data_t                            io_read_data
);

  io_arb_state_t             state_q, state_d;
  logic [NUM_REQUESTERS-1:0] winner_q, winner_d;
  logic                      write_q, write_d;
  io_addr_t                  addr_q, addr_d;
  io_data_t                  wdata_q, wdata_d;
  io_data_t                  rdata_q, rdata_d;

  logic [NUM_REQUESTERS-1:0] arb_req;
  logic [NUM_REQUESTERS-1:0] grant;
  logic                      arb_update;

  // In ISSUE the arbiter sees only the registered winner, so the pointer update
  // lands on winner+1 even if other requests appear meanwhile.
  assign arb_req    = (state_q == StIssue) ? winner_q : req_valid;
  assign arb_update = (state_q == StIssue);

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clk            (clk),
    .reset          (reset),
    .req            (arb_req),
    .update_pointer (arb_update),
    .grant          (grant)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transaction in flight, reads take two extra cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (|req_valid) state_d = StIssue;
      StIssue:    state_d = write_q ? StIdle : StReadWait;
      StReadWait: state_d = StRespond;
      StRespond:  state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Capture the winner's request in IDLE and the bus read data in READ_WAIT.
  always_comb begin
    winner_d = winner_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (state_q == StIdle && |req_valid) begin
      winner_d = grant;
      write_d  = |(grant & req_write);
      for (int j = 0; j < int'(NUM_REQUESTERS); j++) begin
        if (grant[j]) begin
          addr_d  = req_address[j];
          wdata_d = req_write_data[j];
        end
      end
    end
    if (state_q == StReadWait) begin
      rdata_d = io_read_data;
    end
  end

  // Transaction and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      winner_q <= winner_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decode registered state only; the bus is quiet outside ISSUE.
  always_comb begin
    req_ack       = '0;
    resp_valid    = '0;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    unique case (state_q)
      StIssue: begin
        io_write_en   = write_q;
        io_read_en    = !write_q;
        io_address    = addr_q;
        io_write_data = wdata_q;
        req_ack       = winner_q;
      end
      StRespond: resp_valid = winner_q;
      default: ;
    endcase
  end

  assign resp_read_data = rdata_q;

  // A requester must keep req_valid up until the cycle its ack is seen.
  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : gen_hold_chk
    req_held_until_ack : assert property (@(posedge clk) disable iff (reset)
      (req_valid[g] && !req_ack[g]) |=> (req_valid[g] || req_ack[g]));
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed vector table, hand-written multi-cycle
// sequences, and a randomized soak against a transaction-level model.
module tb_io_bus_arbiter;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_write;
  logic [N-1:0][31:0]  req_address;
  logic [N-1:0][31:0]  req_write_data;
  logic [N-1:0]        req_ack;
  logic [N-1:0]        resp_valid;
  logic [31:0]         resp_read_data;
  logic                io_write_en;
  logic                io_read_en;
  logic [31:0]         io_address;
  logic [31:0]         io_write_data;
  logic [31:0]         io_read_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .NUM_REQUESTERS (N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .req_ack        (req_ack),
    .resp_valid     (resp_valid),
    .resp_read_data (resp_read_data),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_address     (io_address),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data)
  );

  function automatic logic [31:0] stub_data(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : ((a ^ 32'hC0DE_0000) + 32'd1);
  endfunction

  // Bus peripheral stub: data appears the cycle after io_read_en, junk otherwise.
  always @(posedge clk) io_read_data <= io_read_en ? stub_data(io_address) : $urandom;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_reqs();
    req_valid      = '0;
    req_write      = '0;
    req_address    = '0;
    req_write_data = '0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    clear_reqs();
    tick();
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " req_ack"}, 32'(req_ack), 32'h0);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, " io_write_en"}, 32'(io_write_en), 32'h0);
    check({tag, " io_read_en"}, 32'(io_read_en), 32'h0);
    check({tag, " io_address"}, io_address, 32'h0);
    check({tag, " io_write_data"}, io_write_data, 32'h0);
  endtask

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } resp_t;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt[6];
    logic [3:0]  ca[10];
    logic [3:0]  mx_ack[6];
    logic        mx_rd[6];
    logic        mx_wr[6];
    logic [3:0]  mx_rv[6];
    logic [N-1:0] pend;
    bit          m_w[N];
    logic [31:0] m_a[N];
    logic [31:0] m_d[N];
    int          waits[N];
    int          ptr;
    int          free_at;
    resp_t       rq[$];

    vt[0] = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0001, 32'h0};
    vt[1] = '{2, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0100, 32'h1234_5678};
    vt[2] = '{1, 1'b0, 32'h0000_0044, 32'h5555_AAAA, 4'b0010, 32'hC0DE_0045};
    vt[3] = '{3, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1000, 32'h0};
    vt[4] = '{3, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001, 4'b1000, 32'h3F21_FFFD};
    vt[5] = '{1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010, 32'h0};

    // Reset state.
    hold_reset();
    check_quiet("reset");
    check("reset resp_read_data", resp_read_data, 32'h0);
    reset = 1'b0;

    // Isolated single transactions from the table.
    for (int i = 0; i < 6; i++) begin
      req_valid[vt[i].id]      = 1'b1;
      req_write[vt[i].id]      = vt[i].wr;
      req_address[vt[i].id]    = vt[i].addr;
      req_write_data[vt[i].id] = vt[i].data;
      tick();
      check($sformatf("vec%0d io_write_en", i), 32'(io_write_en), 32'(vt[i].wr));
      check($sformatf("vec%0d io_read_en", i), 32'(io_read_en), 32'(!vt[i].wr));
      check($sformatf("vec%0d io_address", i), io_address, vt[i].addr);
      check($sformatf("vec%0d io_write_data", i), io_write_data, vt[i].data);
      check($sformatf("vec%0d req_ack", i), 32'(req_ack), 32'(vt[i].ack));
      clear_reqs();
      tick();
      check($sformatf("vec%0d strobes T+2", i), 32'({io_write_en, io_read_en}), 32'h0);
      check($sformatf("vec%0d req_ack T+2", i), 32'(req_ack), 32'h0);
      tick();
      check($sformatf("vec%0d resp_valid T+3", i), 32'(resp_valid),
            vt[i].wr ? 32'h0 : 32'(vt[i].ack));
      if (!vt[i].wr) check($sformatf("vec%0d resp_read_data", i), resp_read_data, vt[i].rdata);
      tick();
      check($sformatf("vec%0d resp_valid T+4", i), 32'(resp_valid), 32'h0);
    end

    // Contention: all four write from reset; requester 0 re-requests at once.
    ca = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
           4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    hold_reset();
    for (int j = 0; j < N; j++) begin
      req_valid[j]      = 1'b1;
      req_write[j]      = 1'b1;
      req_address[j]    = 32'h100 + 32'(j);
      req_write_data[j] = 32'(j);
    end
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      check($sformatf("contend%0d req_ack", t), 32'(req_ack), 32'(ca[t]));
      check($sformatf("contend%0d io_write_en", t), 32'(io_write_en), 32'(ca[t] != 4'b0));
      for (int j = 1; j < N; j++) if (req_ack[j]) req_valid[j] = 1'b0;
    end
    clear_reqs();

    // Mixed: requester 1 read and requester 3 write presented together.
    mx_ack = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    mx_rd  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    mx_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mx_rv  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    hold_reset();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_address[1] = 32'h30;
    req_valid[3] = 1'b1; req_write[3] = 1'b1; req_address[3] = 32'h34;
    req_write_data[3] = 32'hCAFE_F00D;
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      check($sformatf("mixed%0d io_read_en", t), 32'(io_read_en), 32'(mx_rd[t]));
      check($sformatf("mixed%0d io_write_en", t), 32'(io_write_en), 32'(mx_wr[t]));
      check($sformatf("mixed%0d req_ack", t), 32'(req_ack), 32'(mx_ack[t]));
      check($sformatf("mixed%0d resp_valid", t), 32'(resp_valid), 32'(mx_rv[t]));
      if (t == 2) check("mixed resp_read_data", resp_read_data, 32'hC0DE_0031);
      if (t == 4) check("mixed write address", io_address, 32'h34);
      if (req_ack[1]) req_valid[1] = 1'b0;
      if (req_ack[3]) req_valid[3] = 1'b0;
    end
    clear_reqs();

    // Reset while a read from requester 2 is waiting for bus data.
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_address[2] = 32'h20;
    tick();
    check("rstmid io_read_en", 32'(io_read_en), 32'h1);
    check("rstmid req_ack", 32'(req_ack), 32'b0100);
    clear_reqs();
    tick();
    reset = 1'b1;
    #1;
    check_quiet("rstmid during reset");
    check("rstmid resp_read_data", resp_read_data, 32'h0);
    tick();
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("rstmid after%0d resp_valid", t), 32'(resp_valid), 32'h0);
      check($sformatf("rstmid after%0d req_ack", t), 32'(req_ack), 32'h0);
    end
    // Pointer back at 0: requester 1 beats requester 3.
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_address[1] = 32'h40;
    req_valid[3] = 1'b1; req_write[3] = 1'b1; req_address[3] = 32'h44;
    tick();
    check("rstmid first grant", 32'(req_ack), 32'b0010);
    req_valid[1] = 1'b0;
    tick();
    check("rstmid gap", 32'(req_ack), 32'h0);
    tick();
    check("rstmid second grant", 32'(req_ack), 32'b1000);
    clear_reqs();

    // Randomized soak against a transaction-level model.
    hold_reset();
    reset   = 1'b0;
    free_at = cyc;
    ptr     = 0;
    pend    = '0;
    for (int j = 0; j < N; j++) begin
      waits[j] = 0; m_w[j] = 1'b0; m_a[j] = '0; m_d[j] = '0;
    end
    for (int k = 0; k < 10000; k++) begin
      bit exp_strobe;
      int win;
      tick();
      exp_strobe = (cyc - 1 >= free_at) && (pend != '0);
      check("soak single strobe", 32'(io_write_en & io_read_en), 32'h0);
      check("soak strobe", 32'(io_write_en | io_read_en), 32'(exp_strobe));
      if (exp_strobe) begin
        win = -1;
        for (int o = 0; o < N; o++) begin
          int j;
          j = (ptr + o) % N;
          if (win < 0 && pend[j]) win = j;
        end
        check("soak req_ack", 32'(req_ack), 32'(1) << win);
        check("soak io_write_en", 32'(io_write_en), 32'(m_w[win]));
        check("soak io_address", io_address, m_a[win]);
        check("soak io_write_data", io_write_data, m_d[win]);
        for (int j = 0; j < N; j++) begin
          if (pend[j] && j != win) begin
            waits[j]++;
            check("soak fairness", 32'(waits[j] <= N - 1), 32'h1);
          end
        end
        waits[win] = 0;
        pend[win]  = 1'b0;
        ptr        = (win + 1) % N;
        if (!m_w[win]) rq.push_back('{cyc + 2, win, stub_data(m_a[win])});
        free_at = m_w[win] ? cyc + 1 : cyc + 3;
      end else begin
        check("soak idle req_ack", 32'(req_ack), 32'h0);
        check("soak idle io_address", io_address, 32'h0);
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        check("soak resp_valid", 32'(resp_valid), 32'(1) << rq[0].id);
        check("soak resp_read_data", resp_read_data, rq[0].data);
        void'(rq.pop_front());
      end else begin
        check("soak no resp_valid", 32'(resp_valid), 32'h0);
      end
      for (int j = 0; j < N; j++) begin
        if (!pend[j] && $urandom_range(0, 3) == 0) begin
          pend[j]  = 1'b1;
          m_w[j]   = 1'($urandom_range(0, 1));
          m_a[j]   = $urandom & 32'hFFFF_FFFC;
          m_d[j]   = $urandom;
          waits[j] = 0;
        end
        req_valid[j]      = pend[j];
        req_write[j]      = m_w[j];
        req_address[j]    = m_a[j];
        req_write_data[j] = m_d[j];
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single-master IO bus between multiple requesters, such as per-core IO ports or a debug/JTAG host. Each requester gets a simple request/ack/response handshake. The block sits between the requesters and the IO bus bridge that fans the bus out to peripherals. It serialises transactions, grants in round-robin order and returns read data to the originating requester only.

## Interface
Parameters:
- NUM_REQUESTERS, 4, number of requester ports; legal range 1–16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQUESTERS  per-requester request; must be held with fields stable until its req_ack.
- req_write  in  NUM_REQUESTERS  1 = write, 0 = read.
- req_address  in  NUM_REQUESTERS×32  per-requester address.
- req_write_data  in  NUM_REQUESTERS×32  per-requester write data.
- req_ack  out  NUM_REQUESTERS  one-cycle pulse; the request has been issued on the bus.
- resp_valid  out  NUM_REQUESTERS  one-cycle pulse; read data for that requester is on resp_read_data.
- resp_read_data  out  32  read data, shared by all requesters; qualified by resp_valid.
- io_write_en  out  1  bus write strobe.
- io_read_en  out  1  bus read strobe.
- io_address  out  32  bus address.
- io_write_data  out  32  bus write data.
- io_read_data  in  32  bus read data; valid the cycle after io_read_en.

## Operation
- FSM states: IDLE, ISSUE, READ_WAIT, RESPOND.
- IDLE: if any req_valid is set, choose a winner round-robin. Search starts at the priority pointer and increments modulo NUM_REQUESTERS. Register the winner index, write flag, address and data, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive io_write_en or io_read_en high for exactly this cycle, with io_address and io_write_data from the registers. Pulse req_ack[winner]. Set the priority pointer to winner+1, wrapping to 0 after NUM_REQUESTERS-1. A write then goes to IDLE; a read goes to READ_WAIT.
- READ_WAIT: capture io_read_data into the response register, then go to RESPOND.
- RESPOND: pulse resp_valid[winner] with resp_read_data = captured data, then go to IDLE.
- Only one transaction is outstanding at any time. Requests arriving while the FSM is not in IDLE wait; they are evaluated in IDLE.
- When not in ISSUE, io_write_en and io_read_en are 0 and io_address/io_write_data are 0. resp_read_data holds its last value.
- Writes produce no resp_valid.
- A requester that drops req_valid before its ack is illegal; behaviour is undefined and flagged by an assertion.

## Timing
- Reset values: state IDLE, priority pointer 0, and req_ack, resp_valid, io_write_en, io_read_en, io_address, io_write_data, resp_read_data all 0.
- Write: req_valid seen at T (IDLE) → io_write_en and req_ack at T+1 → IDLE at T+2. Sustained throughput is 1 write per 2 cycles.
- Read: seen at T → io_read_en and req_ack at T+1 → io_read_data sampled at T+2 → resp_valid at T+3 → IDLE at T+4.
- All outputs are driven from flops, with no combinational path from req_* to io_* or req_ack.
- Simultaneous requests: exactly one ack per ISSUE cycle, with no starvation. Any continuously asserted requester is granted within NUM_REQUESTERS grants.
- The acked requester may present a new request at T+2. It is arbitrated normally, at lowest priority because the pointer has moved past it.
- Reset asserted mid-transaction: all registers return to reset values immediately. The pending read response is dropped, and no resp_valid or req_ack fires after reset.
- NUM_REQUESTERS = 1: the pointer stays 0 and the FSM is unchanged.

## Structure
- Shared package io_arb_pkg:
  - io_arb_state_t enum {IDLE, ISSUE, READ_WAIT, RESPOND};
  - the io_addr_t/io_data_t 32-bit typedefs.
- One natural sub-module, rr_arbiter:
  - parameter NUM_REQUESTERS;
  - inputs: request vector, update_pointer strobe;
  - output: one-hot grant.
  - It holds the priority pointer and is reused elsewhere in the design.

## Test plan
- Single write: req 0 write addr 0x10, data 0xDEADBEEF → io_write_en one cycle at T+1 with those values, req_ack[0] at T+1, no resp_valid.
- Single read: req 2 read addr 0x20, stub returns 0x12345678 at T+2 → resp_valid[2] at T+3 with resp_read_data 0x12345678, other resp_valid bits 0.
- Contention: reqs 0–3 all writes, held from reset → acks in order 0,1,2,3, each 2 cycles apart. Re-asserting req 0 immediately after its ack does not pre-empt 1–3.
- Mixed read/write back-to-back: req 1 read then req 3 write → io_read_en at T+1, io_write_en at T+5, no bus overlap.
- Reset during READ_WAIT: assert reset at T+2 of a read → all outputs 0 that cycle, no resp_valid afterwards, next request is granted from pointer 0.
- Fairness soak: random valid/write on 4 ports for 10k cycles → scoreboard matches every read, no grant gap above 4 grants for any held request, and never more than one io strobe per cycle.
